// File: rtl/dp_polyvec_split_sched_if.sv
// Bus bundle between the split-polyvec scheduler, its load issuer, the URAM store
// and the read consumers. Signal names are as seen from the scheduler.
interface dp_polyvec_split_sched_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NUM_SPLIT  = 4,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned RD_ID_W    = 1
);
    logic                         i_load_start;
    logic [2:0]                   i_load_nsplit;
    logic                         o_load_busy;
    logic                         o_load_done;
    logic [1:0]                   o_idx_split;
    logic                         o_wruram_start;
    logic                         i_wruram_done;
    logic [NUM_SPLIT-1:0]         o_uram_mem_en;
    logic [NUM_SPLIT-1:0]         o_uram_we;
    logic [ADDR_WIDTH-1:0]        o_uram_rdaddr;
    logic [NUM_RD-1:0]            i_rd_req;
    logic [2*NUM_RD-1:0]          i_rd_split;
    logic [ADDR_WIDTH*NUM_RD-1:0] i_rd_base;
    logic [ADDR_WIDTH*NUM_RD-1:0] i_rd_len;
    logic [NUM_RD-1:0]            o_rd_gnt;
    logic                         o_rd_vld;
    logic [RD_ID_W-1:0]           o_rd_id;
    logic                         o_rd_last;

    // Scheduler side.
    modport slave (
        input  i_load_start, i_load_nsplit, i_wruram_done,
        input  i_rd_req, i_rd_split, i_rd_base, i_rd_len,
        output o_load_busy, o_load_done, o_idx_split, o_wruram_start,
        output o_uram_mem_en, o_uram_we, o_uram_rdaddr,
        output o_rd_gnt, o_rd_vld, o_rd_id, o_rd_last
    );

    // Issuer / store / consumer side.
    modport master (
        output i_load_start, i_load_nsplit, i_wruram_done,
        output i_rd_req, i_rd_split, i_rd_base, i_rd_len,
        input  o_load_busy, o_load_done, o_idx_split, o_wruram_start,
        input  o_uram_mem_en, o_uram_we, o_uram_rdaddr,
        input  o_rd_gnt, o_rd_vld, o_rd_id, o_rd_last
    );
endinterface

// File: rtl/dp_polyvec_split_sched.sv
// Sequencer for the split ciphertext polyvec URAM store: first kicks one TPP->URAM
// copy per split, then shares the store among NUM_RD burst readers round-robin.
// Every output is a flop, loaded from the next-state values.
module dp_polyvec_split_sched #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NUM_SPLIT  = 4,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned RD_ID_W    = 1,
    parameter int unsigned RD_LAT     = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    dp_polyvec_split_sched_if.slave bus_io
);
    localparam int unsigned DrnW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {StIdle, StLoadKick, StLoadWait, StRdBurst, StRdDrain} state_e;

    state_e                state_q, state_d;
    logic [2:0]            nsp_q, nsp_d;
    logic [1:0]            sidx_q, sidx_d;
    logic                  seen_low_q, seen_low_d;
    logic [1:0]            rsplit_q, rsplit_d;
    logic [ADDR_WIDTH-1:0] rbase_q, rbase_d, rlen_q, rlen_d, beat_q, beat_d;
    logic [RD_ID_W-1:0]    rid_q, rid_d, ptr_q, ptr_d;
    logic [DrnW-1:0]       drn_q, drn_d;

    logic                  busy_q, busy_d, done_q, done_d, start_q, start_d;
    logic [1:0]            idx_q, idx_d;
    logic [NUM_SPLIT-1:0]  mem_en_q, mem_en_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;
    logic [NUM_RD-1:0]     gnt_q, gnt_d;
    // Address-cycle tag, launched into the delay line to meet the read data.
    logic                  act_q, act_d, alast_q, alast_d;
    logic [RD_ID_W-1:0]    aid_q, aid_d;

    logic [RD_LAT-1:0]              dl_vld_q, dl_last_q;
    logic [RD_LAT-1:0][RD_ID_W-1:0] dl_id_q;

    logic                  found;
    logic [RD_ID_W-1:0]    sel, cand;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            nsp_q      <= '0;
            sidx_q     <= '0;
            seen_low_q <= 1'b0;
            rsplit_q   <= '0;
            rbase_q    <= '0;
            rlen_q     <= '0;
            beat_q     <= '0;
            rid_q      <= '0;
            ptr_q      <= '0;
            drn_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            idx_q      <= '0;
            mem_en_q   <= '0;
            we_q       <= '0;
            rdaddr_q   <= '0;
            gnt_q      <= '0;
            act_q      <= 1'b0;
            alast_q    <= 1'b0;
            aid_q      <= '0;
        end else begin
            state_q    <= state_d;
            nsp_q      <= nsp_d;
            sidx_q     <= sidx_d;
            seen_low_q <= seen_low_d;
            rsplit_q   <= rsplit_d;
            rbase_q    <= rbase_d;
            rlen_q     <= rlen_d;
            beat_q     <= beat_d;
            rid_q      <= rid_d;
            ptr_q      <= ptr_d;
            drn_q      <= drn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            start_q    <= start_d;
            idx_q      <= idx_d;
            mem_en_q   <= mem_en_d;
            we_q       <= we_d;
            rdaddr_q   <= rdaddr_d;
            gnt_q      <= gnt_d;
            act_q      <= act_d;
            alast_q    <= alast_d;
            aid_q      <= aid_d;
        end
    end

    // Next state: load-over-read priority in idle, copy sequencing, burst and drain counting.
    always_comb begin
        state_d    = state_q;
        nsp_d      = nsp_q;
        sidx_d     = sidx_q;
        seen_low_d = seen_low_q;
        rsplit_d   = rsplit_q;
        rbase_d    = rbase_q;
        rlen_d     = rlen_q;
        beat_d     = beat_q;
        rid_d      = rid_q;
        ptr_d      = ptr_q;
        drn_d      = drn_q;
        done_d     = 1'b0;
        gnt_d      = '0;
        found      = 1'b0;
        sel        = ptr_q;
        cand       = ptr_q;
        // Search starts one past the last grant so the last winner has lowest priority.
        for (int unsigned k = 1; k <= NUM_RD; k++) begin
            cand = RD_ID_W'((32'(ptr_q) + k) % NUM_RD);
            if (!found && bus_io.i_rd_req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        case (state_q)
            StIdle: begin
                if (bus_io.i_load_start) begin
                    nsp_d  = (bus_io.i_load_nsplit > 3'(NUM_SPLIT)) ? 3'(NUM_SPLIT)
                                                                    : bus_io.i_load_nsplit;
                    sidx_d = '0;
                    if (nsp_d == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StLoadKick;
                    end
                end else if (found) begin
                    gnt_d[sel] = 1'b1;
                    rsplit_d   = bus_io.i_rd_split[2*sel +: 2];
                    rbase_d    = bus_io.i_rd_base[ADDR_WIDTH*sel +: ADDR_WIDTH];
                    rlen_d     = bus_io.i_rd_len[ADDR_WIDTH*sel +: ADDR_WIDTH];
                    rid_d      = sel;
                    ptr_d      = sel;
                    beat_d     = '0;
                    state_d    = StRdBurst;
                end
            end
            StLoadKick: begin
                state_d    = StLoadWait;
                seen_low_d = 1'b0;
            end
            StLoadWait: begin
                // The store's done flag is stale for a cycle after the kick; only a
                // low-then-high sequence marks this copy as finished.
                if (!bus_io.i_wruram_done) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    if (({1'b0, sidx_q} + 3'd1) < nsp_q) begin
                        sidx_d  = sidx_q + 2'd1;
                        state_d = StLoadKick;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StRdBurst: begin
                if (beat_q == rlen_q) begin
                    drn_d   = '0;
                    state_d = StRdDrain;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StRdDrain: begin
                if (drn_q == DrnW'(RD_LAT - 1)) begin
                    state_d = StIdle;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        busy_d   = 1'b0;
        start_d  = 1'b0;
        idx_d    = '0;
        mem_en_d = '0;
        we_d     = '0;
        rdaddr_d = '0;
        act_d    = 1'b0;
        alast_d  = 1'b0;
        aid_d    = rid_d;
        case (state_d)
            StLoadKick: begin
                busy_d           = 1'b1;
                start_d          = 1'b1;
                idx_d            = sidx_d;
                mem_en_d[sidx_d] = 1'b1;
                we_d[sidx_d]     = 1'b1;
            end
            StLoadWait: begin
                busy_d           = 1'b1;
                idx_d            = sidx_d;
                mem_en_d[sidx_d] = 1'b1;
                we_d[sidx_d]     = 1'b1;
            end
            StRdBurst: begin
                idx_d              = rsplit_d;
                mem_en_d[rsplit_d] = 1'b1;
                rdaddr_d           = rbase_d + beat_d;
                act_d              = 1'b1;
                alast_d            = (beat_d == rlen_d);
            end
            StRdDrain: begin
                // Keep the store's output mux on this split until the last beat lands.
                idx_d              = rsplit_d;
                mem_en_d[rsplit_d] = 1'b1;
                rdaddr_d           = rdaddr_q;
            end
            default: ;
        endcase
    end

    // Delay line aligning vld/id/last with the store's read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_vld_q  <= '0;
            dl_last_q <= '0;
            dl_id_q   <= '0;
        end else begin
            dl_vld_q[0]  <= act_q;
            dl_last_q[0] <= alast_q;
            dl_id_q[0]   <= aid_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_last_q[i] <= dl_last_q[i-1];
                dl_id_q[i]   <= dl_id_q[i-1];
            end
        end
    end

    assign bus_io.o_load_busy    = busy_q;
    assign bus_io.o_load_done    = done_q;
    assign bus_io.o_idx_split    = idx_q;
    assign bus_io.o_wruram_start = start_q;
    assign bus_io.o_uram_mem_en  = mem_en_q;
    assign bus_io.o_uram_we      = we_q;
    assign bus_io.o_uram_rdaddr  = rdaddr_q;
    assign bus_io.o_rd_gnt       = gnt_q;
    assign bus_io.o_rd_vld       = dl_vld_q[RD_LAT-1];
    assign bus_io.o_rd_id        = dl_id_q[RD_LAT-1];
    assign bus_io.o_rd_last      = dl_last_q[RD_LAT-1];
endmodule

// File: tb/tb_dp_polyvec_split_sched.sv
// Bench for dp_polyvec_split_sched: table of read bursts, hand-written load and
// reset sequences, and scoreboards for read beats and copy kicks.
module tb_dp_polyvec_split_sched;
    localparam int unsigned AW = 12;
    localparam int unsigned NS = 4;
    localparam int unsigned NR = 2;
    localparam int unsigned IW = 1;
    localparam int unsigned RL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dp_polyvec_split_sched_if #(.ADDR_WIDTH(AW), .NUM_SPLIT(NS), .NUM_RD(NR), .RD_ID_W(IW)) ifc ();

    dp_polyvec_split_sched #(
        .ADDR_WIDTH(AW), .NUM_SPLIT(NS), .NUM_RD(NR), .RD_ID_W(IW), .RD_LAT(RL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_io(ifc)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_seen = 0;
    int exp_done = 0;

    typedef struct {
        int          cyc;
        logic [IW-1:0] id;
        logic        last;
        logic [1:0]  split;
    } beat_t;
    typedef struct {
        logic [1:0]    idx;
        logic [NS-1:0] we;
    } kick_t;
    typedef struct {
        int unsigned   rq;
        logic [1:0]    split;
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic [NS-1:0] mem_en;
    } rdv_t;

    beat_t dq[$];
    kick_t kq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Store model: done drops the cycle after a kick and stays low for 10 cycles.
    int st_cnt = 0;
    logic st_seen = 1'b0;
    initial ifc.i_wruram_done = 1'b1;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            st_cnt = 0;
            st_seen = 1'b0;
        end else begin
            if (st_cnt != 0) st_cnt = st_cnt - 1;
            if (st_seen) st_cnt = 10;
            st_seen = ifc.o_wruram_start;
        end
        ifc.i_wruram_done = (st_cnt == 0);
    end

    // Read-data and kick scoreboards.
    always @(negedge clk) begin
        beat_t e;
        kick_t k;
        logic [NS-1:0] m;
        if (ifc.o_rd_vld) begin
            if (dq.size() == 0) begin
                chk("unexpected_vld", 32'(ifc.o_rd_vld), 32'(0));
            end else begin
                e = dq.pop_front();
                m = NS'(1) << e.split;
                chk("vld_cycle", 32'(cyc), 32'(e.cyc));
                chk("vld_id", 32'(ifc.o_rd_id), 32'(e.id));
                chk("vld_last", 32'(ifc.o_rd_last), 32'(e.last));
                chk("vld_idx_split", 32'(ifc.o_idx_split), 32'(e.split));
                chk("vld_mem_en", 32'(ifc.o_uram_mem_en), 32'(m));
            end
        end
        if (ifc.o_wruram_start) begin
            if (kq.size() == 0) begin
                chk("unexpected_kick", 32'(ifc.o_wruram_start), 32'(0));
            end else begin
                k = kq.pop_front();
                chk("kick_idx", 32'(ifc.o_idx_split), 32'(k.idx));
                chk("kick_we", 32'(ifc.o_uram_we), 32'(k.we));
                chk("kick_mem_en", 32'(ifc.o_uram_mem_en), 32'(k.we));
                chk("kick_busy", 32'(ifc.o_load_busy), 32'(1));
            end
        end
        if (ifc.o_load_done) begin
            done_seen++;
            chk("done_busy_low", 32'(ifc.o_load_busy), 32'(0));
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 32'(ifc.o_load_busy), 32'(0));
        chk({nm, "_done"}, 32'(ifc.o_load_done), 32'(0));
        chk({nm, "_start"}, 32'(ifc.o_wruram_start), 32'(0));
        chk({nm, "_idx"}, 32'(ifc.o_idx_split), 32'(0));
        chk({nm, "_mem_en"}, 32'(ifc.o_uram_mem_en), 32'(0));
        chk({nm, "_we"}, 32'(ifc.o_uram_we), 32'(0));
        chk({nm, "_rdaddr"}, 32'(ifc.o_uram_rdaddr), 32'(0));
        chk({nm, "_gnt"}, 32'(ifc.o_rd_gnt), 32'(0));
        chk({nm, "_vld"}, 32'(ifc.o_rd_vld), 32'(0));
    endtask

    // Issue a load and wait (bounded) for its done pulse.
    task automatic run_load(input logic [2:0] ns, input string nm);
        int w;
        ifc.i_load_nsplit = ns;
        ifc.i_load_start = 1'b1;
        tick();
        ifc.i_load_start = 1'b0;
        w = 0;
        while (!ifc.o_load_done && w < 200) begin
            tick();
            w++;
        end
        chk({nm, "_done"}, 32'(ifc.o_load_done), 32'(1));
        chk({nm, "_kicks_left"}, 32'(kq.size()), 32'(0));
        tick();
        chk({nm, "_done_one_pulse"}, 32'(ifc.o_load_done), 32'(0));
    endtask

    initial begin
        rdv_t tv[4];
        int c0;
        int w;
        logic [AW-1:0] ea;
        logic [NS-1:0] m;

        tv[0] = '{rq: 0, split: 2'd2, base: 12'h010, len: 12'd3, mem_en: 4'b0100};
        tv[1] = '{rq: 1, split: 2'd0, base: 12'hFFE, len: 12'd3, mem_en: 4'b0001};
        tv[2] = '{rq: 1, split: 2'd3, base: 12'h100, len: 12'd0, mem_en: 4'b1000};
        tv[3] = '{rq: 0, split: 2'd1, base: 12'h7FF, len: 12'd1, mem_en: 4'b0010};

        ifc.i_load_start = 1'b0;
        ifc.i_load_nsplit = '0;
        ifc.i_rd_req = '0;
        ifc.i_rd_split = '0;
        ifc.i_rd_base = '0;
        ifc.i_rd_len = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Both requesters held, single-beat bursts: pointer starts at 0 so 1 wins first.
        ifc.i_rd_split = {2'd3, 2'd1};
        ifc.i_rd_base = {12'h200, 12'h100};
        ifc.i_rd_len = '0;
        ifc.i_rd_req = 2'b11;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            dq.push_back('{cyc: c0 + 1 + 4 * i + int'(RL), id: IW'((i + 1) % 2), last: 1'b1,
                           split: (i % 2 == 0) ? 2'd3 : 2'd1});
        end
        for (int i = 0; i < 4; i++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (ifc.o_rd_gnt == '0 && w < 20);
            chk("alt_gnt", 32'(ifc.o_rd_gnt), (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("alt_gnt_cycle", 32'(cyc), 32'(c0 + 1 + 4 * i));
            chk("alt_rdaddr", 32'(ifc.o_uram_rdaddr), (i % 2 == 0) ? 32'h200 : 32'h100);
            if (i == 3) ifc.i_rd_req = '0;
        end
        repeat (6) tick();
        chk("alt_beats_left", 32'(dq.size()), 32'(0));

        // Table of single-requester bursts.
        for (int i = 0; i < 4; i++) begin
            ifc.i_rd_split[2*tv[i].rq +: 2] = tv[i].split;
            ifc.i_rd_base[AW*tv[i].rq +: AW] = tv[i].base;
            ifc.i_rd_len[AW*tv[i].rq +: AW] = tv[i].len;
            ifc.i_rd_req[tv[i].rq] = 1'b1;
            c0 = cyc;
            for (int k = 0; k <= int'(tv[i].len); k++) begin
                dq.push_back('{cyc: c0 + 1 + k + int'(RL), id: IW'(tv[i].rq),
                               last: (k == int'(tv[i].len)), split: tv[i].split});
            end
            tick();
            m = NR'(1) << tv[i].rq;
            chk("tv_gnt", 32'(ifc.o_rd_gnt), 32'(m));
            ifc.i_rd_req = '0;
            for (int k = 0; k <= int'(tv[i].len); k++) begin
                if (k > 0) begin
                    tick();
                    chk("tv_gnt_pulse", 32'(ifc.o_rd_gnt), 32'(0));
                end
                ea = tv[i].base + AW'(k);
                chk("tv_rdaddr", 32'(ifc.o_uram_rdaddr), 32'(ea));
                chk("tv_mem_en", 32'(ifc.o_uram_mem_en), 32'(tv[i].mem_en));
                chk("tv_we", 32'(ifc.o_uram_we), 32'(0));
                chk("tv_idx", 32'(ifc.o_idx_split), 32'(tv[i].split));
            end
            for (int d = 0; d < int'(RL); d++) begin
                tick();
                chk("tv_drain_mem_en", 32'(ifc.o_uram_mem_en), 32'(tv[i].mem_en));
                chk("tv_drain_idx", 32'(ifc.o_idx_split), 32'(tv[i].split));
            end
            tick();
            chk("tv_idle_mem_en", 32'(ifc.o_uram_mem_en), 32'(0));
        end
        chk("tv_beats_left", 32'(dq.size()), 32'(0));

        // Load three splits.
        kq.push_back('{idx: 2'd0, we: 4'b0001});
        kq.push_back('{idx: 2'd1, we: 4'b0010});
        kq.push_back('{idx: 2'd2, we: 4'b0100});
        exp_done++;
        run_load(3'd3, "load3");

        // Zero splits: done next cycle, no kick.
        ifc.i_load_nsplit = 3'd0;
        ifc.i_load_start = 1'b1;
        exp_done++;
        tick();
        ifc.i_load_start = 1'b0;
        chk("load0_done", 32'(ifc.o_load_done), 32'(1));
        chk("load0_start", 32'(ifc.o_wruram_start), 32'(0));
        tick();
        chk("load0_done_one_pulse", 32'(ifc.o_load_done), 32'(0));

        // Six requested, clamped to four.
        for (int s = 0; s < 4; s++) kq.push_back('{idx: 2'(s), we: 4'(1) << s});
        exp_done++;
        run_load(3'd6, "load6");

        // Load and read request in the same idle cycle: load first, grant right after done.
        ifc.i_rd_split[2*1 +: 2] = 2'd2;
        ifc.i_rd_base[AW*1 +: AW] = 12'h020;
        ifc.i_rd_len[AW*1 +: AW] = 12'd1;
        ifc.i_rd_req = 2'b10;
        ifc.i_load_nsplit = 3'd1;
        ifc.i_load_start = 1'b1;
        kq.push_back('{idx: 2'd0, we: 4'b0001});
        exp_done++;
        tick();
        ifc.i_load_start = 1'b0;
        chk("mix_busy", 32'(ifc.o_load_busy), 32'(1));
        chk("mix_no_gnt", 32'(ifc.o_rd_gnt), 32'(0));
        w = 0;
        while (!ifc.o_load_done && w < 200) begin
            tick();
            w++;
        end
        chk("mix_done", 32'(ifc.o_load_done), 32'(1));
        chk("mix_gnt_at_done", 32'(ifc.o_rd_gnt), 32'(0));
        c0 = cyc;
        for (int k = 0; k < 2; k++) begin
            dq.push_back('{cyc: c0 + 1 + k + int'(RL), id: IW'(1), last: (k == 1), split: 2'd2});
        end
        tick();
        chk("mix_gnt_after_done", 32'(ifc.o_rd_gnt), 32'(2));
        ifc.i_rd_req = '0;
        repeat (6) tick();
        chk("mix_beats_left", 32'(dq.size()), 32'(0));

        // Reset in the middle of LOAD_WAIT, then a fresh load restarts at split 0.
        kq.push_back('{idx: 2'd0, we: 4'b0001});
        ifc.i_load_nsplit = 3'd2;
        ifc.i_load_start = 1'b1;
        tick();
        ifc.i_load_start = 1'b0;
        repeat (4) tick();
        chk("midrst_busy_before", 32'(ifc.o_load_busy), 32'(1));
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        repeat (14) tick();
        chk("midrst_no_done", 32'(done_seen), 32'(exp_done));
        chk("midrst_busy_after", 32'(ifc.o_load_busy), 32'(0));
        kq.push_back('{idx: 2'd0, we: 4'b0001});
        exp_done++;
        run_load(3'd1, "reload");

        repeat (4) tick();
        chk("final_beats_left", 32'(dq.size()), 32'(0));
        chk("final_kicks_left", 32'(kq.size()), 32'(0));
        chk("final_done_count", 32'(done_seen), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/dp_polyvec_split_sched.md
Name: dp_polyvec_split_sched

Overview:
- Controller that sequences and shares the split ciphertext polyvec URAM store (NUM_SPLIT splits, each two polyvec URAMs).
- Phase 1 (load): kicks the TPP-to-URAM copy once per split, steering split index, mem_en and we for each.
- Phase 2 (read): round-robin arbitrates burst read requests from NUM_RD consumers and drives split index, mem_en and read address.
- Returns a tagged valid strobe aligned with the store's read data; the store's output mux is driven by o_idx_split.

Parameters:
- ADDR_WIDTH, 12, URAM word address width.
- NUM_SPLIT, 4, number of splits (equals MAX_N_SPLIT); split index is 2 bits.
- NUM_RD, 2, number of read requesters.
- RD_ID_W, 1, width of the requester tag; clog2(NUM_RD), minimum 1.
- RD_LAT, 2, URAM read latency (COMMON_URAM_DELAY), address cycle to data cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_load_start  in  1  load command pulse; accepted only in IDLE.
- i_load_nsplit  in  3  number of splits to load, 0..NUM_SPLIT.
- o_load_busy  out  1  high from acceptance until o_load_done.
- o_load_done  out  1  one-cycle pulse when the load sequence ends.
- o_idx_split  out  2  split select to the polyvec store.
- o_wruram_start  out  1  one-cycle copy kick to the store.
- i_wruram_done  in  1  store idle flag; low while a copy is running.
- o_uram_mem_en  out  NUM_SPLIT  per-split enable.
- o_uram_we  out  NUM_SPLIT  per-split write enable.
- o_uram_rdaddr  out  ADDR_WIDTH  read address.
- i_rd_req  in  NUM_RD  level request per requester.
- i_rd_split  in  2*NUM_RD  split index per requester.
- i_rd_base  in  ADDR_WIDTH*NUM_RD  burst base address per requester.
- i_rd_len  in  ADDR_WIDTH*NUM_RD  burst beats minus one per requester.
- o_rd_gnt  out  NUM_RD  one-hot one-cycle grant pulse.
- o_rd_vld  out  1  read data valid, aligned with the store's data output.
- o_rd_id  out  RD_ID_W  requester tag for o_rd_vld.
- o_rd_last  out  1  marks the final beat of a burst.

Behaviour:
- Reset: rst_n low at a clock edge drives all outputs to 0, state to IDLE, RR pointer to 0, and clears the vld/id/last delay line. Applies mid-load or mid-burst; no completion pulse is produced.
- All outputs are registered.
- States: IDLE, LOAD_KICK, LOAD_WAIT, RD_BURST, RD_DRAIN.
- IDLE arbitration: if i_load_start is high, load wins over any i_rd_req.
  - Load: latch n = min(i_load_nsplit, NUM_SPLIT) and set split s=0.
  - If n==0, pulse o_load_done next cycle and stay in IDLE.
- LOAD_KICK (1 cycle): o_wruram_start=1, o_idx_split=s, we[s]=mem_en[s]=1. Go to LOAD_WAIT and clear the seen_low flag.
- LOAD_WAIT: hold we[s]/mem_en[s]. Set seen_low when i_wruram_done==0. Leave only when seen_low and i_wruram_done==1:
  - s+1<n: s++, go to LOAD_KICK.
  - otherwise: deassert we/mem_en, pulse o_load_done, go to IDLE.
- o_load_busy is high in LOAD_KICK and LOAD_WAIT.
- Read grant (IDLE, no load): choose the first requesting index strictly after the last-granted index, modulo NUM_RD.
  - Pulse o_rd_gnt, latch split/base/len/id, update the pointer, go to RD_BURST.
  - A requester must drop i_rd_req the cycle after its grant; a request still high is treated as a new request.
- RD_BURST: one address per cycle, o_uram_rdaddr = base + beat, modulo 2^ADDR_WIDTH (wraps). mem_en[split]=1, we=0, o_idx_split=split.
  - After beat len (len+1 beats total), go to RD_DRAIN.
- Data strobe: o_rd_vld, o_rd_id and o_rd_last are asserted exactly RD_LAT cycles after their address cycle, via the delay line.
- RD_DRAIN: lasts RD_LAT cycles; o_idx_split and mem_en[split] are held so the store's output mux stays correct until the last data. Then go to IDLE.
  - No grant or load start during drain; a load request waits (level held by the upstream issuer).
- i_load_start outside IDLE is ignored.
- Bits of i_rd_split above 2 do not exist; values are used as-is with NUM_SPLIT=4.

Test Plan:
- Load nsplit=3, model store done low 1 cycle after start for 10 cycles → three start pulses with idx_split 0,1,2; we one-hot 0001, 0010, 0100; o_load_done one pulse after the third done-high; busy low after.
- Load nsplit=0 → o_load_done the next cycle, no o_wruram_start. Load nsplit=6 → exactly 4 kicks.
- Read req0 split=2 base=0x010 len=3 → gnt0, rdaddr 0x010..0x013 with mem_en=0100; vld four beats RD_LAT later; id=0; last on the 4th beat; idx_split=2 held until the last vld.
- req0 and req1 held continuously, len=0 → grants alternate 1,0,1,0 starting after pointer reset to 0; each burst is separated by RD_LAT drain cycles.
- Base 0xFFE len=3 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- load_start and req1 in the same IDLE cycle → load runs first, req1 granted after o_load_done. rst_n low during LOAD_WAIT → all outputs 0, no done pulse, new load restarts at split 0.
